// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pkg
// Brief    : Shared widths, FSM state type and idle/line encoding for the
//            sequenced 5-to-32 decoder. DECODER_ACTIVE_LOW_EN selects
//            inverted (one-cold) output polarity.
// Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam int IDX_W = 5;
    localparam int OUT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_t;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] OUT_IDLE = {OUT_W{1'b1}};
`else
    localparam logic [OUT_W-1:0] OUT_IDLE = {OUT_W{1'b0}};
`endif

    // XOR with the idle pattern turns one-hot into one-cold when inverted.
    function automatic logic [OUT_W-1:0] decode_idx(input logic [IDX_W-1:0] idx);
        logic [OUT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v ^ OUT_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : decoder_fifo2
// Brief    : Two-entry index FIFO with 1-bit pointers and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_fifo2
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [IDX_W-1:0] i_data,
    output logic [IDX_W-1:0] o_data,
    output logic [1:0]       o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [IDX_W-1:0] r_mem [0:1];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);

endmodule
`default_nettype wire

// File: rtl/decoder_32bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_32bit_seq
// Brief    : Buffered 5-to-32 decoder; each strobe is held for at least
//            HOLD_CYCLES cycles then released on out_ready. Define
//            DECODER_ACTIVE_LOW_EN for one-cold (inverted) output.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_32bit_seq
    import decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i,
    input  logic             gs,
    output logic             in_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eo
);

    localparam int             CNT_W        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(HOLD_CYCLES - 1);
    localparam state_t         c_load_state = (HOLD_CYCLES == 1) ? WAIT : HOLD;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [OUT_W-1:0] r_out;
    logic [OUT_W-1:0] w_out_next;
    logic             r_valid;
    logic             w_valid_next;

    logic             w_push;
    logic             w_pop;
    logic [IDX_W-1:0] w_fifo_data;
    logic [1:0]       w_count;
    logic             w_full;
    logic             w_empty;

    assign in_ready = !w_full && !rst;
    assign w_push   = gs && in_ready;

    decoder_fifo2 u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i),
        .o_data  (w_fifo_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_out_next   = r_out;
        w_valid_next = r_valid;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                w_pop = !w_empty;
            end
            HOLD: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (out_ready) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_out_next   = OUT_IDLE;
                        w_valid_next = 1'b0;
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A pop always coincides with loading the next strobe (back-to-back).
        if (w_pop) begin
            w_state_next = c_load_state;
            w_cnt_next   = c_cnt_load;
            w_out_next   = decode_idx(w_fifo_data);
            w_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= OUT_IDLE;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_out   <= w_out_next;
            r_valid <= w_valid_next;
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign eo        = (w_count == 2'd0) && (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_decoder_32bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_32bit_seq
// Brief    : Directed self-checking bench; instance a uses HOLD_CYCLES=1,
//            instance b uses HOLD_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_32bit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ia, ib;
    logic        gsa, gsb;
    logic        rdya, rdyb;
    logic        in_rdya, in_rdyb;
    logic [31:0] outa, outb;
    logic        vala, valb;
    logic        eoa, eob;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    decoder_32bit_seq #(.HOLD_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .i(ia), .gs(gsa), .in_ready(in_rdya),
        .out(outa), .out_valid(vala), .out_ready(rdya), .eo(eoa)
    );

    decoder_32bit_seq #(.HOLD_CYCLES(4)) u_dut_b (
        .clk(clk), .rst(rst), .i(ib), .gs(gsb), .in_ready(in_rdyb),
        .out(outb), .out_valid(valb), .out_ready(rdyb), .eo(eob)
    );

`ifdef DECODER_ACTIVE_LOW_EN
    localparam logic [31:0] c_idle = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] c_idle = 32'h0000_0000;
`endif

    // Expected line pattern from a hand-computed one-hot constant.
    function automatic logic [31:0] exp_line(input logic [31:0] onehot);
        return onehot ^ c_idle;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ia = '0; ib = '0; gsa = 1'b0; gsb = 1'b0; rdya = 1'b0; rdyb = 1'b1;

        // Reset
        tick;
        chk("rst_in_ready_a", 32'(in_rdya), 32'd0);
        chk("rst_in_ready_b", 32'(in_rdyb), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("rst_out", outa, c_idle);
        chk("rst_valid", 32'(vala), 32'd0);
        chk("rst_eo", 32'(eoa), 32'd1);
        chk("rst_in_ready", 32'(in_rdya), 32'd1);

        // Single decode, HOLD_CYCLES=1
        rdya = 1'b1; ia = 5'd19; gsa = 1'b1;
        tick;
        gsa = 1'b0;
        chk("single_latency", 32'(vala), 32'd0);
        tick;
        chk("single_out", outa, exp_line(32'h0008_0000));
        chk("single_valid", 32'(vala), 32'd1);
        tick;
        chk("single_release", outa, c_idle);
        chk("single_valid0", 32'(vala), 32'd0);
        chk("single_eo", 32'(eoa), 32'd1);

        // Backpressure: 0, 31, 7 accepted; 2 dropped
        rdya = 1'b0; ia = 5'd0; gsa = 1'b1;
        tick;
        ia = 5'd31;
        tick;
        chk("bp_first", outa, exp_line(32'h0000_0001));
        ia = 5'd7;
        tick;
        chk("bp_hold", outa, exp_line(32'h0000_0001));
        chk("bp_full", 32'(in_rdya), 32'd0);
        ia = 5'd2;
        tick;
        chk("bp_drop_rdy", 32'(in_rdya), 32'd0);
        chk("bp_drop_out", outa, exp_line(32'h0000_0001));
        gsa = 1'b0; rdya = 1'b1;
        tick;
        chk("bp_31", outa, exp_line(32'h8000_0000));
        chk("bp_31_valid", 32'(vala), 32'd1);
        tick;
        chk("bp_7", outa, exp_line(32'h0000_0080));
        tick;
        chk("bp_end", outa, c_idle);
        chk("bp_end_valid", 32'(vala), 32'd0);
        tick;
        chk("bp_no2", outa, c_idle);
        chk("bp_eo", 32'(eoa), 32'd1);

        // HOLD_CYCLES=4: i=3 held 4 cycles, queued 9 follows without a gap
        ib = 5'd3; gsb = 1'b1;
        tick;
        ib = 5'd9;
        tick;
        gsb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold4_3_c%0d", k), outb, exp_line(32'h0000_0008));
            tick;
        end
        chk("hold4_9", outb, exp_line(32'h0000_0200));
        chk("hold4_9_valid", 32'(valb), 32'd1);
        tick; tick; tick;
        chk("hold4_9_last", outb, exp_line(32'h0000_0200));
        tick;
        chk("hold4_end", outb, c_idle);
        chk("hold4_eo", 32'(eob), 32'd1);

        // Reset mid-operation with full FIFO and strobe in HOLD
        rdyb = 1'b0; ib = 5'd5; gsb = 1'b1;
        tick;
        ib = 5'd6;
        tick;
        ib = 5'd10;
        tick;
        gsb = 1'b0;
        chk("mid_out", outb, exp_line(32'h0000_0020));
        chk("mid_full", 32'(in_rdyb), 32'd0);
        rst = 1'b1;
        tick;
        rst = 1'b0; rdyb = 1'b1;
        chk("mid_rst_out", outb, c_idle);
        chk("mid_rst_valid", 32'(valb), 32'd0);
        chk("mid_rst_eo", 32'(eob), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick;
            chk($sformatf("mid_stale_%0d", k), outb, c_idle);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
